// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths and the register-file write request
// carried through the writeback arbiter.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [NREGS-1:0]  regmask_t;

  typedef struct packed {
    regbits_t wsel;
    word_t    wdat;
  } rfw_req_t;

endpackage

// File: rtl/rfw_fifo.sv
// Small circular FIFO of register-file write requests, with a per-entry
// valid/wsel view so the owner can build a pending-write mask.
module rfw_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  rfw_req_t                 push_data_i,
  input  logic                     pop_i,
  output rfw_req_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [DEPTH-1:0]         ent_valid_o,
  output regbits_t [DEPTH-1:0]     ent_wsel_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  rfw_req_t         mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];
  assign ent_valid_o = valid_q;

  always_comb begin
    ent_wsel_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_wsel_o[i] = mem_q[i].wsel;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (do_pop) begin
      rptr_d          = rptr_q + PW'(1);
      valid_d[rptr_q] = 1'b0;
    end
    if (do_push) begin
      wptr_d          = wptr_q + PW'(1);
      valid_d[wptr_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage needs no reset; valid_q gates every consumer.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (A, strict
// priority) and buffered mult/div results (B), with starvation relief and a busy mask.
module rf_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   a_wen,
  input  regbits_t               a_wsel,
  input  word_t                  a_wdat,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  regbits_t               b_wsel,
  input  word_t                  b_wdat,
  output logic                   rf_wen,
  output regbits_t               rf_wsel,
  output word_t                  rf_wdat,
  output regmask_t               busy_mask,
  output logic                   pipe_stall,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_HI  = SW'(STARVE_MAX - 1);

  logic                 a_win, push, pop;
  logic                 full, empty;
  rfw_req_t             head;
  logic [DEPTH-1:0]     ent_valid;
  regbits_t [DEPTH-1:0] ent_wsel;

  logic     rf_wen_q, rf_wen_d;
  regbits_t rf_wsel_q, rf_wsel_d;
  word_t    rf_wdat_q, rf_wdat_d;
  logic [SW-1:0] starve_q, starve_d;

  // Writes to r0 are architecturally void: an A write to r0 frees the port,
  // and a B result for r0 is acknowledged but never queued.
  assign a_win   = a_wen && (a_wsel != '0);
  assign b_ready = !full;
  assign push    = b_valid && b_ready && (b_wsel != '0);
  assign pop     = !a_win && !empty;

  rfw_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .push_i      (push),
    .push_data_i ('{wsel: b_wsel, wdat: b_wdat}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (full),
    .empty_o     (empty),
    .ent_valid_o (ent_valid),
    .ent_wsel_o  (ent_wsel)
  );

  always_comb begin
    rf_wen_d  = 1'b0;
    rf_wsel_d = rf_wsel_q;
    rf_wdat_d = rf_wdat_q;
    if (a_win) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = a_wsel;
      rf_wdat_d = a_wdat;
    end else if (pop) begin
      rf_wen_d  = 1'b1;
      rf_wsel_d = head.wsel;
      rf_wdat_d = head.wdat;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (a_win && (starve_q != STARVE_SAT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Stays asserted while saturated so an ignoring pipeline keeps being asked.
  assign pipe_stall = a_win && (starve_q >= STARVE_HI);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rf_wen_q  <= 1'b0;
      rf_wsel_q <= '0;
      rf_wdat_q <= '0;
      starve_q  <= '0;
    end else begin
      rf_wen_q  <= rf_wen_d;
      rf_wsel_q <= rf_wsel_d;
      rf_wdat_q <= rf_wdat_d;
      starve_q  <= starve_d;
    end
  end

  assign rf_wen  = rf_wen_q;
  assign rf_wsel = rf_wsel_q;
  assign rf_wdat = rf_wdat_q;

  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i]) begin
        busy_mask[ent_wsel[i]] = 1'b1;
      end
    end
    if (rf_wen_q) begin
      busy_mask[rf_wsel_q] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomised + directed bench for rf_write_arbiter: queue-based reference model,
// expected register-file writes checked by an independent monitor.
module tb_rf_write_arbiter;
  import cpu_types_pkg::*;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       a_wen, b_valid, b_ready, rf_wen, pipe_stall;
  regbits_t   a_wsel, b_wsel, rf_wsel;
  word_t      a_wdat, b_wdat, rf_wdat;
  regmask_t   busy_mask;
  logic [2:0] fifo_count;

  rf_write_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .a_wen      (a_wen),
    .a_wsel     (a_wsel),
    .a_wdat     (a_wdat),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_wsel     (b_wsel),
    .b_wdat     (b_wdat),
    .rf_wen     (rf_wen),
    .rf_wsel    (rf_wsel),
    .rf_wdat    (rf_wdat),
    .busy_mask  (busy_mask),
    .pipe_stall (pipe_stall),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: pending B results, expected port writes, starvation count.
  rfw_req_t mq[$];
  rfw_req_t exp_q[$];
  rfw_req_t mon_e;
  int       m_starve;
  logic     m_rf_wen;
  regbits_t m_rf_wsel;
  logic     exp_stall;
  logic     obs_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].wsel] = 1'b1;
    if (m_rf_wen) m[m_rf_wsel] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic step(input logic aw, input regbits_t as, input word_t ad,
                      input logic bv, input regbits_t bs, input word_t bd);
    int       s0;
    logic     awin;
    rfw_req_t h;
    @(negedge CLK);
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("b_ready", 32'(b_ready), 32'(mq.size() < DEPTH));
    chk("busy_mask", busy_mask, model_busy());
    chk("rf_wen", 32'(rf_wen), 32'(m_rf_wen));
    a_wen = aw; a_wsel = as; a_wdat = ad;
    b_valid = bv; b_wsel = bs; b_wdat = bd;
    #1;
    s0        = mq.size();
    awin      = aw && (as != 0);
    exp_stall = awin && (m_starve >= STARVE_MAX - 1);
    obs_stall = pipe_stall;
    chk("pipe_stall", 32'(pipe_stall), 32'(exp_stall));
    if (s0 > 0 && awin) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
    else m_starve = 0;
    if (awin) begin
      exp_q.push_back(rfw_req_t'{wsel: as, wdat: ad});
      m_rf_wen  = 1'b1;
      m_rf_wsel = as;
    end else if (s0 > 0) begin
      h = mq.pop_front();
      exp_q.push_back(h);
      m_rf_wen  = 1'b1;
      m_rf_wsel = h.wsel;
    end else begin
      m_rf_wen = 1'b0;
    end
    if (bv && s0 < DEPTH && bs != 0) mq.push_back(rfw_req_t'{wsel: bs, wdat: bd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; a_wen = 1'b0; b_valid = 1'b1; b_wsel = 5'd7; b_wdat = 32'h1234_5678;
    repeat (2) @(negedge CLK);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_wsel", 32'(rf_wsel), 32'd0);
    chk("rst_rf_wdat", rf_wdat, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    nRST = 1'b1; b_valid = 1'b0;
    mq.delete(); exp_q.delete();
    m_starve = 0; m_rf_wen = 1'b0; m_rf_wsel = '0; exp_stall = 1'b0;
  endtask

  // Monitor: every presented write must be the next one the model predicted.
  always @(posedge CLK) begin
    #1;
    if (rf_wen === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rf_write: got write wsel=%0d wdat=%h want none at %0t", rf_wsel, rf_wdat, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rf_wsel", 32'(rf_wsel), 32'(mon_e.wsel));
        chk("rf_wdat", rf_wdat, mon_e.wdat);
      end
    end
  end

  initial begin
    int first;
    logic aw;
    nRST = 1'b0; a_wen = 1'b0; a_wsel = '0; a_wdat = '0;
    b_valid = 1'b0; b_wsel = '0; b_wdat = '0;
    m_starve = 0; m_rf_wen = 1'b0; m_rf_wsel = '0; exp_stall = 1'b0; obs_stall = 1'b0;

    do_reset();

    // Idle drain of a single B result
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    idle(4);

    // A every cycle while B overfills the FIFO
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'(1 + i), $urandom, 1'b1, 5'(8 + i), $urandom);
    // Full with simultaneous pop, then the retried push is accepted
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'hC0DE_0013);
    step(1'b1, 5'd2, 32'h0000_0A02, 1'b1, 5'd13, 32'hC0DE_0013);
    idle(6);

    // Starvation: one queued result, A writes continuously
    step(1'b1, 5'd3, 32'h0000_0A03, 1'b1, 5'd9, 32'h0000_0B09);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'd0);
      if (obs_stall && first == 0) first = k;
      if (first != 0) break;
    end
    chk("stall_cycle", 32'(first), 32'd8);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd4, 32'h0000_0A04, 1'b0, 5'd0, 32'd0);

    // Ignored stall: starve saturates and the request persists
    step(1'b1, 5'd3, 32'h0000_0A05, 1'b1, 5'd10, 32'h0000_0B10);
    for (int k = 0; k < 12; k++) step(1'b1, 5'd6, $urandom, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Zero register on both ports
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 5'd2, 32'h0000_0A06, 1'b1, 5'd6, 32'h0000_0B06);
    step(1'b1, 5'd0, 32'h0000_0A00, 1'b0, 5'd0, 32'd0);
    idle(2);

    // Random traffic, pipeline usually honouring pipe_stall, one mid-run reset
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      aw = ($urandom_range(0, 9) < 7);
      if (exp_stall && $urandom_range(0, 7) != 0) aw = 1'b0;
      step(aw, 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end
    idle(DEPTH + 4);

    @(posedge CLK);
    #2;
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
